// File: rtl/test_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : test_seq_ctrl
//  Description : Avalon-MM controlled test sequencer. Sweeps a programmable
//                read-address range over the operand RAMs and replays the
//                same addresses, LAT cycles later, as result RAM write
//                addresses with per-channel write enables. Supports repeat
//                passes, abort and a sticky done status.
//                Optional: define TEST_SEQ_CYCLE_COUNT_EN to build the busy
//                cycle counter at register 7 (otherwise register 7 reads 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module test_seq_ctrl #(
    parameter int          ADDR_W = 11,
    parameter int          NUM_CH = 2,
    parameter int          LAT    = 2,
    parameter logic [31:0] ID     = 32'd2
) (
    input  logic              avalon_clock,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    input  logic              pll_lock,
    output logic [ADDR_W-1:0] r_addr,
    output logic              re,
    output logic [ADDR_W-1:0] w_addr,
    output logic [NUM_CH-1:0] we
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Every valid-pipeline stage except the output stage; when these are
    // empty and no read is issued, the output stage holds the final write.
    localparam logic [LAT-1:0] c_LOW_MASK = {LAT{1'b1}} >> 1;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W:0]     r_end;
    logic [15:0]         r_loops;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_mask_lat;
    logic [15:0]         r_loop_cnt;
    logic [LAT-1:0]      r_vpipe;
    logic [ADDR_W-1:0]   r_apipe [LAT];

    logic                w_go;
    logic                w_abort;
    logic                w_accept_go;
    logic                w_restart;
    logic                w_re;
    logic                w_busy;
    logic                w_done;
    logic                w_last;
    logic                w_drained;
    logic                w_empty_range;
    logic [ADDR_W:0]     w_addr_inc;
    logic [31:0]         w_cycles;
    logic                w_unused_wdata;

    assign w_go          = write && (address == 3'd0) && writedata[0];
    assign w_abort       = write && (address == 3'd0) && writedata[1];
    assign w_done        = (r_state == S_DONE);
    assign w_empty_range = (r_end <= {1'b0, r_start});
    // Compare in ADDR_W+1 bits so END = 2^ADDR_W ends at the top address
    assign w_addr_inc    = {1'b0, r_addr} + (ADDR_W + 1)'(1);
    assign w_last        = (w_addr_inc >= r_end);
    assign w_drained     = ((r_vpipe & c_LOW_MASK) == '0) && !w_re;
    assign w_unused_wdata = ^writedata;

    // State register
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_re        = 1'b0;
        w_busy      = 1'b0;
        w_accept_go = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    w_accept_go = 1'b1;
                    w_state_nxt = w_empty_range ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_re   = 1'b1;
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_drained) begin
                    if (r_loop_cnt != 16'd0) begin
                        w_restart   = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_accept_go = 1'b0;
            w_restart   = 1'b0;
        end
    end

    // Configuration registers, frozen while a sweep is in progress
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            r_start <= '0;
            r_end   <= '0;
            r_loops <= '0;
            r_mask  <= '0;
        end else if (write && !w_busy) begin
            case (address)
                3'd1:    r_start <= writedata[ADDR_W-1:0];
                3'd2:    r_end   <= writedata[ADDR_W:0];
                3'd3:    r_loops <= writedata[15:0];
                3'd4:    r_mask  <= writedata[NUM_CH-1:0];
                default: ;
            endcase
        end
    end

    // Read address sweep, pass counter and channel mask snapshot
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_loop_cnt <= '0;
            r_mask_lat <= '0;
        end else if (w_accept_go) begin
            r_addr     <= r_start;
            r_loop_cnt <= r_loops;
            r_mask_lat <= r_mask;
        end else if (w_restart) begin
            r_addr     <= r_start;
            r_loop_cnt <= r_loop_cnt - 16'd1;
        end else if (w_re && !w_last) begin
            r_addr     <= r_addr + ADDR_W'(1);
        end
    end

    // Read-to-write delay line for valid and address; abort flushes valid
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            r_vpipe <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_apipe[i] <= '0;
            end
        end else begin
            if (w_abort) begin
                r_vpipe <= '0;
            end else begin
                r_vpipe[0] <= w_re;
                for (int i = 1; i < LAT; i++) begin
                    r_vpipe[i] <= r_vpipe[i-1];
                end
            end
            r_apipe[0] <= r_addr;
            for (int i = 1; i < LAT; i++) begin
                r_apipe[i] <= r_apipe[i-1];
            end
        end
    end

`ifdef TEST_SEQ_CYCLE_COUNT_EN
    logic [31:0] r_cycles;

    // Busy-cycle counter: cleared on GO, saturating, frozen when idle
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_accept_go) begin
            r_cycles <= '0;
        end else if (w_busy && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = 32'd0;
`endif

    // Registered read data, held when no read is issued
    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                3'd0:    readdata <= {29'd0, pll_lock, w_done, w_busy};
                3'd1:    readdata <= 32'(r_start);
                3'd2:    readdata <= 32'(r_end);
                3'd3:    readdata <= 32'(r_loops);
                3'd4:    readdata <= 32'(r_mask);
                3'd6:    readdata <= ID;
                3'd7:    readdata <= w_cycles;
                default: readdata <= 32'd0;
            endcase
        end
    end

    assign re     = w_re;
    assign w_addr = r_apipe[LAT-1];
    assign we     = r_vpipe[LAT-1] ? r_mask_lat : '0;

endmodule
`default_nettype wire

// File: tb/tb_test_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_seq_ctrl
//  Description : Self-checking bench for test_seq_ctrl. A cycle-indexed
//                expected trace is computed from START/END/LOOPS/ABORT and
//                compared against the DUT outputs and status reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_seq_ctrl;

    localparam int LAT  = 2;
    localparam int MAXK = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic        pll_lock;
    logic        sel;

    logic        write_a, write_b, read_a, read_b;
    logic [31:0] a_rd, b_rd;
    logic [10:0] a_ra, a_wa;
    logic [3:0]  b_ra, b_wa;
    logic        a_re, b_re;
    logic [1:0]  a_we, b_we;

    logic [31:0] obs_rd;
    logic [15:0] obs_ra, obs_wa;
    logic        obs_re;
    logic [1:0]  obs_we;

    int checks   = 0;
    int failures = 0;

    int m_re   [MAXK];
    int m_ra   [MAXK];
    int m_we   [MAXK];
    int m_wa   [MAXK];
    int m_busy [MAXK];
    int m_done [MAXK];

    always #5 clk = ~clk;

    assign write_a = write & ~sel;
    assign write_b = write &  sel;
    assign read_a  = read  & ~sel;
    assign read_b  = read  &  sel;
    assign obs_rd  = sel ? b_rd : a_rd;
    assign obs_ra  = sel ? 16'(b_ra) : 16'(a_ra);
    assign obs_wa  = sel ? 16'(b_wa) : 16'(a_wa);
    assign obs_re  = sel ? b_re : a_re;
    assign obs_we  = sel ? b_we : a_we;

    test_seq_ctrl #(.ADDR_W(11), .NUM_CH(2), .LAT(LAT), .ID(32'd2)) u_dut_a (
        .avalon_clock (clk),
        .reset        (rst),
        .address      (address),
        .write        (write_a),
        .writedata    (writedata),
        .read         (read_a),
        .readdata     (a_rd),
        .pll_lock     (pll_lock),
        .r_addr       (a_ra),
        .re           (a_re),
        .w_addr       (a_wa),
        .we           (a_we)
    );

    test_seq_ctrl #(.ADDR_W(4), .NUM_CH(2), .LAT(LAT), .ID(32'd5)) u_dut_b (
        .avalon_clock (clk),
        .reset        (rst),
        .address      (address),
        .write        (write_b),
        .writedata    (writedata),
        .read         (read_b),
        .readdata     (b_rd),
        .pll_lock     (pll_lock),
        .r_addr       (b_ra),
        .re           (b_re),
        .w_addr       (b_wa),
        .we           (b_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1; read = 1'b0;
        step();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a; read = 1'b1; write = 1'b0;
        step();
        read = 1'b0;
        d = obs_rd;
    endtask

    // Expected trace indexed by cycle after GO (cycle 1 = first cycle after
    // the GO edge): each pass issues N reads, then LAT idle drain cycles;
    // writes mirror reads LAT cycles later; done follows the last drain.
    task automatic build_model(input int st, input int en, input int loops,
                               input int abort_at, input int aw, output int total);
        int n;
        int k;
        for (int i = 0; i < MAXK; i++) begin
            m_re[i] = 0; m_ra[i] = 0; m_we[i] = 0; m_wa[i] = 0;
            m_busy[i] = 0; m_done[i] = 0;
        end
        n     = en - st;
        total = (n > 0) ? (loops + 1) * (n + LAT) : 0;
        k     = 1;
        if (n > 0) begin
            for (int p = 0; p <= loops; p++) begin
                for (int i = 0; i < n; i++) begin
                    if (k < MAXK) begin
                        m_re[k] = 1;
                        m_ra[k] = (st + i) % (1 << aw);
                    end
                    k++;
                end
                k += LAT;
            end
        end
        for (int j = 1; j + LAT < MAXK; j++) begin
            if (m_re[j] != 0) begin
                m_we[j+LAT] = 1;
                m_wa[j+LAT] = m_ra[j];
            end
        end
        for (int j = 1; j < MAXK; j++) begin
            m_busy[j] = (j <= total) ? 1 : 0;
            m_done[j] = (j >  total) ? 1 : 0;
        end
        if (abort_at > 0) begin
            for (int j = abort_at + 1; j < MAXK; j++) begin
                m_re[j] = 0; m_we[j] = 0; m_busy[j] = 0; m_done[j] = 0;
            end
        end
    endtask

    // Program, GO, then step cycle by cycle comparing outputs and a
    // continuous status read. With side_wr, writes START/END/GO mid-run.
    task automatic run_go(input string tag, input int st, input int en, input int loops,
                          input int mask, input int abort_at, input bit side_wr, input int aw);
        int  total;
        int  ncyc;
        bit  rd_prev;
        bit  wr_now;
        logic [1:0] emask;
        emask = 2'(mask);
        bus_write(3'd1, 32'(st));
        bus_write(3'd2, 32'(en));
        bus_write(3'd3, 32'(loops));
        bus_write(3'd4, 32'(mask));
        build_model(st, en, loops, abort_at, aw, total);
        ncyc = (abort_at > 0) ? abort_at + 4 : total + 3;
        if (ncyc >= MAXK) ncyc = MAXK - 1;
        bus_write(3'd0, 32'd1);
        rd_prev = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            chk({tag, ".re"}, 32'(obs_re), 32'(m_re[k]));
            if (m_re[k] != 0) chk({tag, ".r_addr"}, 32'(obs_ra), 32'(m_ra[k]));
            chk({tag, ".we"}, 32'(obs_we), (m_we[k] != 0) ? 32'(emask) : 32'd0);
            if (m_we[k] != 0) chk({tag, ".w_addr"}, 32'(obs_wa), 32'(m_wa[k]));
            if (rd_prev) chk({tag, ".status"}, 32'(obs_rd[1:0]),
                             32'({m_done[k-1] != 0, m_busy[k-1] != 0}));
            wr_now    = 1'b0;
            write     = 1'b0;
            read      = 1'b1;
            address   = 3'd0;
            if (side_wr && k == 2) begin wr_now = 1'b1; address = 3'd1; writedata = 32'd50; end
            if (side_wr && k == 3) begin wr_now = 1'b1; address = 3'd2; writedata = 32'd60; end
            if (side_wr && k == 4) begin wr_now = 1'b1; address = 3'd0; writedata = 32'd1;  end
            if (abort_at > 0 && k == abort_at) begin
                wr_now = 1'b1; address = 3'd0; writedata = 32'd3;
            end
            if (wr_now) begin write = 1'b1; read = 1'b0; end
            rd_prev = !wr_now;
            step();
        end
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int st, en, lp, mk;
        rst = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
        pll_lock = 1'b1; sel = 1'b0;

        // Reset state
        step(); step();
        chk("rst.re",     32'(a_re), 32'd0);
        chk("rst.r_addr", 32'(a_ra), 32'd0);
        chk("rst.w_addr", 32'(a_wa), 32'd0);
        chk("rst.we",     32'(a_we), 32'd0);
        chk("rst.rdata",  a_rd,      32'd0);
        chk("rst.b_we",   32'(b_we), 32'd0);
        rst = 1'b0;
        step();
        for (int r = 0; r < 8; r++) begin
            bus_read(3'(r), d);
            chk($sformatf("rst.reg%0d", r), d,
                (r == 0) ? 32'd4 : (r == 6) ? 32'd2 : 32'd0);
        end
        sel = 1'b1;
        bus_read(3'd6, d);
        chk("b.id", d, 32'd5);
        sel = 1'b0;
        pll_lock = 1'b0;

        // Basic sweep, both channels
        run_go("basic", 4, 8, 0, 3, 0, 1'b0, 11);
        bus_read(3'd0, d);
        chk("basic.reg0", d, 32'd2);
        bus_read(3'd7, d);
        chk("basic.reg7", d, 32'd0);

        // Repeat passes on channel 0 only
        run_go("loop", 0, 3, 2, 1, 0, 1'b0, 11);
        bus_read(3'd0, d);
        chk("loop.reg0", d, 32'd2);

        // Empty range: straight to done
        run_go("empty", 10, 10, 0, 3, 0, 1'b0, 11);

        // Abort at the 5th run cycle; config writes and GO while busy ignored
        run_go("abort", 0, 100, 0, 3, 5, 1'b1, 11);
        bus_read(3'd0, d);
        chk("abort.reg0", d, 32'd0);
        bus_read(3'd1, d);
        chk("abort.start", d, 32'd0);
        bus_read(3'd2, d);
        chk("abort.end", d, 32'd100);

        // Top of memory, END = 2^ADDR_W, one extra pass
        run_go("top", 2044, 2048, 1, 2, 0, 1'b0, 11);

        // Narrow instance: top of a 16-word memory
        sel = 1'b1;
        run_go("narrow", 12, 16, 0, 3, 0, 1'b0, 4);
        bus_read(3'd0, d);
        chk("narrow.reg0", d, 32'd2);
        sel = 1'b0;

        // Randomized runs
        for (int t = 0; t < 8; t++) begin
            st = int'($urandom_range(0, 2047));
            en = st + int'($urandom_range(0, 14)) - 2;
            if (en < 0) en = 0;
            if (en > 2048) en = 2048;
            lp = int'($urandom_range(0, 2));
            mk = int'($urandom_range(0, 3));
            run_go($sformatf("rnd%0d", t), st, en, lp, mk, 0, 1'b0, 11);
        end

        // Asynchronous reset in the middle of a run
        bus_write(3'd1, 32'd0);
        bus_write(3'd2, 32'd50);
        bus_write(3'd0, 32'd1);
        step(); step(); step(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst.re",     32'(a_re), 32'd0);
        chk("arst.r_addr", 32'(a_ra), 32'd0);
        chk("arst.w_addr", 32'(a_wa), 32'd0);
        chk("arst.we",     32'(a_we), 32'd0);
        step();
        rst = 1'b0;
        step();
        bus_read(3'd2, d);
        chk("arst.end", d, 32'd0);
        bus_read(3'd0, d);
        chk("arst.reg0", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
